// File: rtl/if_stage_pkg.sv
// Shared fetch/decode constants: bubble encoding, reset PC, instruction field
// positions and the base-ISA opcodes that control_unit also decodes.
package if_stage_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0013;  // addi x0,x0,0
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP           = 32'd4;

  localparam int OP_LSB     = 0;
  localparam int OP_MSB     = 6;
  localparam int RD_LSB     = 7;
  localparam int RD_MSB     = 11;
  localparam int FUNCT3_LSB = 12;
  localparam int FUNCT3_MSB = 14;
  localparam int RS1_LSB    = 15;
  localparam int RS1_MSB    = 19;
  localparam int RS2_LSB    = 20;
  localparam int RS2_MSB    = 24;
  localparam int FUNCT7_LSB = 25;
  localparam int FUNCT7_MSB = 31;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } ifid_t;

  function automatic ifid_t ifid_bubble(input logic [XLEN-1:0] nop);
    ifid_t b;
    b.instr    = nop;
    b.pc       = '0;
    b.pc_plus4 = '0;
    b.valid    = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register. Reset and flush both insert a bubble; flush wins
// over stall so a squashed slot can never be held in decode.
module if_id_reg
  import if_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  i_stall,
  input  logic  i_flush,
  input  ifid_t i_d,
  output ifid_t o_q
);

  ifid_t r_q;

  always_ff @(posedge clk) begin
    if (rst)          r_q <= ifid_bubble(NOP_INSTR);
    else if (i_flush) r_q <= ifid_bubble(NOP_INSTR);
    else if (!i_stall) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/if_stage.sv
// Fetch stage: PC register with redirect/stall priority, PC+4 adder, and the
// IF/ID register with decode field slices.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEFAULT,
  parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            StallF,
  input  logic            StallD,
  input  logic            FlushD,
  input  logic            PCSrcE,
  input  logic [XLEN-1:0] PCTargetE,
  input  logic [XLEN-1:0] InstrF,
  output logic [XLEN-1:0] PCF,
  output logic [XLEN-1:0] InstrD,
  output logic [XLEN-1:0] PCD,
  output logic [XLEN-1:0] PCPlus4D,
  output logic            ValidD,
  output logic [6:0]      opD,
  output logic [2:0]      funct3D,
  output logic [6:0]      funct7D,
  output logic [4:0]      Rs1D,
  output logic [4:0]      Rs2D,
  output logic [4:0]      RdD
);

  // Only the word address is stored, so PCF[1:0] is zero by construction.
  logic [XLEN-1:2] r_pc_w;
  logic [XLEN-1:2] w_pc_next_w;
  logic [XLEN-1:0] w_pc;
  logic [XLEN-1:0] w_pc_plus4;
  ifid_t           w_ifid_d;
  ifid_t           w_ifid_q;

  assign w_pc       = {r_pc_w, 2'b00};
  assign w_pc_plus4 = w_pc + PC_STEP;

  // Redirect beats stall so a resolved branch is never dropped.
  always_comb begin
    w_pc_next_w = w_pc_plus4[XLEN-1:2];
    if (PCSrcE)      w_pc_next_w = PCTargetE[XLEN-1:2];
    else if (StallF) w_pc_next_w = r_pc_w;
  end

  always_ff @(posedge clk) begin
    if (rst) r_pc_w <= RESET_PC[XLEN-1:2];
    else     r_pc_w <= w_pc_next_w;
  end

  assign PCF = w_pc;

  always_comb begin
    w_ifid_d          = '0;
    w_ifid_d.instr    = InstrF;
    w_ifid_d.pc       = w_pc;
    w_ifid_d.pc_plus4 = w_pc_plus4;
    w_ifid_d.valid    = 1'b1;
  end

  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .i_stall (StallD),
    .i_flush (FlushD),
    .i_d     (w_ifid_d),
    .o_q     (w_ifid_q)
  );

  assign InstrD   = w_ifid_q.instr;
  assign PCD      = w_ifid_q.pc;
  assign PCPlus4D = w_ifid_q.pc_plus4;
  assign ValidD   = w_ifid_q.valid;

  assign opD     = InstrD[OP_MSB:OP_LSB];
  assign RdD     = InstrD[RD_MSB:RD_LSB];
  assign funct3D = InstrD[FUNCT3_MSB:FUNCT3_LSB];
  assign Rs1D    = InstrD[RS1_MSB:RS1_LSB];
  assign Rs2D    = InstrD[RS2_MSB:RS2_LSB];
  assign funct7D = InstrD[FUNCT7_MSB:FUNCT7_LSB];

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reset, stall, redirect/flush, wrap, decode
// fields and reset during stall, with hand-computed expectations.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst, StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE, InstrF;
  logic [31:0] PCF, InstrD, PCD, PCPlus4D;
  logic        ValidD;
  logic [6:0]  opD, funct7D;
  logic [2:0]  funct3D;
  logic [4:0]  Rs1D, Rs2D, RdD;
  logic [31:0] wPCF, wInstrD, wPCD, wPCPlus4D;
  logic        wValidD;
  logic [6:0]  wopD, wfunct7D;
  logic [2:0]  wfunct3D;
  logic [4:0]  wRs1D, wRs2D, wRdD;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  if_stage u_dut (
    .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .InstrF(InstrF),
    .PCF(PCF), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD),
    .opD(opD), .funct3D(funct3D), .funct7D(funct7D),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PCSrcE(PCSrcE), .PCTargetE(PCTargetE), .InstrF(InstrF),
    .PCF(wPCF), .InstrD(wInstrD), .PCD(wPCD), .PCPlus4D(wPCPlus4D), .ValidD(wValidD),
    .opD(wopD), .funct3D(wfunct3D), .funct7D(wfunct7D),
    .Rs1D(wRs1D), .Rs2D(wRs2D), .RdD(wRdD)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle on the falling edge for sampling/driving.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_d(input string tag, input logic [31:0] pcf, input logic [31:0] ins,
                       input logic [31:0] pcd, input logic [31:0] p4d, input logic v);
    chk({tag, ".PCF"}, PCF, pcf);
    chk({tag, ".InstrD"}, InstrD, ins);
    chk({tag, ".PCD"}, PCD, pcd);
    chk({tag, ".PCPlus4D"}, PCPlus4D, p4d);
    chk({tag, ".ValidD"}, {31'd0, ValidD}, {31'd0, v});
  endtask

  initial begin
    rst = 1'b1; StallF = 0; StallD = 0; FlushD = 0; PCSrcE = 0;
    PCTargetE = 32'h0; InstrF = 32'h0000_0293;
    @(negedge clk);
    step();
    // Reset must dominate a concurrent redirect/stall/flush.
    PCSrcE = 1; PCTargetE = 32'h0000_0040; StallF = 1; StallD = 1; FlushD = 0;
    step();
    chk_d("reset", 32'h0, 32'h0000_0013, 32'h0, 32'h0, 1'b0);
    chk("wrap.reset_PCF", wPCF, 32'hFFFF_FFFC);
    chk("wrap.reset_ValidD", {31'd0, wValidD}, 32'd0);

    rst = 0; PCSrcE = 0; PCTargetE = 32'h0; StallF = 0; StallD = 0;
    step();
    chk_d("fetch1", 32'h4, 32'h0000_0293, 32'h0, 32'h4, 1'b1);
    chk("wrap.PCF", wPCF, 32'h0);
    chk("wrap.PCD", wPCD, 32'hFFFF_FFFC);
    chk("wrap.PCPlus4D", wPCPlus4D, 32'h0);
    step();
    chk_d("fetch2", 32'h8, 32'h0000_0293, 32'h4, 32'h8, 1'b1);

    StallF = 1; StallD = 1; InstrF = 32'h4030_82B3;
    step();
    chk_d("stall1", 32'h8, 32'h0000_0293, 32'h4, 32'h8, 1'b1);
    step();
    chk_d("stall2", 32'h8, 32'h0000_0293, 32'h4, 32'h8, 1'b1);
    StallF = 0; StallD = 0;
    step();
    chk_d("unstall", 32'hC, 32'h4030_82B3, 32'h8, 32'hC, 1'b1);
    chk("dec.opD", {25'd0, opD}, 32'h33);
    chk("dec.funct3D", {29'd0, funct3D}, 32'h0);
    chk("dec.funct7D", {25'd0, funct7D}, 32'h20);
    chk("dec.Rs1D", {27'd0, Rs1D}, 32'd1);
    chk("dec.Rs2D", {27'd0, Rs2D}, 32'd3);
    chk("dec.RdD", {27'd0, RdD}, 32'd5);

    // StallF alone: PC held, decode reloads the same fetch slot.
    StallF = 1; InstrF = 32'h0010_0093;
    step();
    chk_d("stallF_only", 32'hC, 32'h0010_0093, 32'hC, 32'h10, 1'b1);

    PCSrcE = 1; PCTargetE = 32'h0000_0103; FlushD = 1; StallF = 1; StallD = 1;
    step();
    chk_d("redir_flush", 32'h100, 32'h0000_0013, 32'h0, 32'h0, 1'b0);
    PCSrcE = 0; FlushD = 0; StallF = 0; StallD = 0; InstrF = 32'h0020_0113;
    step();
    chk_d("after_redir", 32'h104, 32'h0020_0113, 32'h100, 32'h104, 1'b1);

    PCSrcE = 1; PCTargetE = 32'h0000_0016;
    step();
    chk_d("redir_20", 32'h14, 32'h0020_0113, 32'h104, 32'h108, 1'b1);

    // Reset during a stall with a pending redirect.
    StallF = 1; StallD = 1; PCSrcE = 1; PCTargetE = 32'h0000_0200; rst = 1;
    step();
    chk_d("rst_mid", 32'h0, 32'h0000_0013, 32'h0, 32'h0, 1'b0);
    rst = 0; StallF = 0; StallD = 0; PCSrcE = 0;
    step();
    chk_d("post_rst1", 32'h4, 32'h0020_0113, 32'h0, 32'h4, 1'b1);
    step();
    chk_d("post_rst2", 32'h8, 32'h0020_0113, 32'h4, 32'h8, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
